// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus: decode/execute/memory stage fields in,
// freeze/flush/forward controls and event counters out.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int ST_W  = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [RA_W-1:0]  id_src1;
  logic [RA_W-1:0]  id_src2;
  logic             id_use_src2;
  logic             ex_valid;
  logic             ex_wb_en;
  logic             ex_mem_read;
  logic [RA_W-1:0]  ex_dest;
  logic             mem_wb_en;
  logic [RA_W-1:0]  mem_dest;
  logic             branch_taken;
  logic             ex_s;
  logic [ST_W-1:0]  ex_status;
  logic             freeze;
  logic             flush;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic [ST_W-1:0]  status;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: presents stage information, consumes controls.
  modport master (
    output id_valid, id_src1, id_src2, id_use_src2,
    output ex_valid, ex_wb_en, ex_mem_read, ex_dest,
    output mem_wb_en, mem_dest, branch_taken, ex_s, ex_status,
    input  freeze, flush, fwd_sel1, fwd_sel2,
    input  status, state, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid, id_src1, id_src2, id_use_src2,
    input  ex_valid, ex_wb_en, ex_mem_read, ex_dest,
    input  mem_wb_en, mem_dest, branch_taken, ex_s, ex_status,
    output freeze, flush, fwd_sel1, fwd_sel2,
    output status, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a short in-order pipeline: detects read-after-write
// hazards at decode, optionally selects operand forwarding, stretches branch
// flushes, latches the condition flags and counts stall/flush events.
module pipe_hazard_ctrl #(
  parameter int RA_W      = 4,
  parameter int ST_W      = 4,
  parameter int FWD_EN    = 0,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  // Flush cycles remaining after the branch cycle itself.
  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYC - 1);

  state_t           state_q;
  logic [2:0]       fcnt_q;
  logic [ST_W-1:0]  status_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [RA_W-1:0]  src1;
  logic [RA_W-1:0]  src2;
  logic [RA_W-1:0]  ex_dest;
  logic [RA_W-1:0]  mem_dest;
  logic             hit_ex1;
  logic             hit_ex2;
  logic             hit_mem1;
  logic             hit_mem2;
  logic             hazard;
  logic             flush_raw;
  logic             freeze;
  logic             flush;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Youngest producer wins: EXE result is newer than MEM result.
  function automatic logic [1:0] fwd_pick(input logic he, input logic hm);
    if (he)      return 2'b01;
    else if (hm) return 2'b10;
    return 2'b00;
  endfunction

  assign src1     = bus.id_src1;
  assign src2     = bus.id_src2;
  assign ex_dest  = bus.ex_dest;
  assign mem_dest = bus.mem_dest;

  // Register-match terms, src2 only counts when the instruction reads it.
  always_comb begin
    hit_ex1  = bus.ex_wb_en  && (ex_dest  == src1);
    hit_mem1 = bus.mem_wb_en && (mem_dest == src1);
    hit_ex2  = bus.id_use_src2 && bus.ex_wb_en  && (ex_dest  == src2);
    hit_mem2 = bus.id_use_src2 && bus.mem_wb_en && (mem_dest == src2);
  end

  // Hazard and forward selection; with forwarding only a load result still
  // in EXE cannot be bypassed.
  always_comb begin
    hazard   = 1'b0;
    fwd_sel1 = 2'b00;
    fwd_sel2 = 2'b00;
    if (FWD_EN != 0) begin
      hazard   = bus.id_valid && bus.ex_mem_read && (hit_ex1 || hit_ex2);
      fwd_sel1 = fwd_pick(hit_ex1, hit_mem1);
      fwd_sel2 = fwd_pick(hit_ex2, hit_mem2);
    end else begin
      hazard   = bus.id_valid && (hit_ex1 || hit_mem1 || hit_ex2 || hit_mem2);
    end
  end

  // Branch beats hazard; reset masks both controls immediately.
  always_comb begin
    flush_raw = bus.branch_taken || (state_q == FLUSH);
    flush     = rst && flush_raw;
    freeze    = rst && hazard && !flush_raw;
  end

  // Control FSM with flush stretch counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else if (bus.branch_taken) begin
      if (FLUSH_CYC > 1) begin
        state_q <= FLUSH;
        fcnt_q  <= FCNT_LOAD;
      end else begin
        state_q <= RUN;
        fcnt_q  <= 3'd0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          if (fcnt_q > 3'd1) begin
            fcnt_q <= fcnt_q - 3'd1;
          end else begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
          end
        end
        STALL: begin
          if (!hazard) state_q <= RUN;
        end
        default: begin
          if (hazard) state_q <= STALL;
          else        state_q <= RUN;
        end
      endcase
    end
  end

  // Condition flags follow S-bit instructions leaving EXE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q <= '0;
    end else if (bus.ex_valid && bus.ex_s) begin
      status_q <= bus.ex_status;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze)           stall_cnt_q <= sat_inc(stall_cnt_q);
      if (bus.branch_taken) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.freeze    = freeze;
  assign bus.flush     = flush;
  assign bus.fwd_sel1  = fwd_sel1;
  assign bus.fwd_sel2  = fwd_sel2;
  assign bus.status    = status_q;
  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 4, register-index width.
REQ-002 SHALL have parameter ST_W, default 4, status-register width (N,Z,C,V).
REQ-003 SHALL have parameter FWD_EN, default 0; 0 = stall on any RAW, 1 = stall only on load-use and emit forward selects.
REQ-004 SHALL have parameter FLUSH_CYC, default 1, range 1-7, cycles flush stays asserted per taken branch.
REQ-005 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset (one clock; reset is synchronous and active-low).
REQ-007 SHALL have ports: id_valid in 1; id_src1 in RA_W; id_src2 in RA_W; id_use_src2 in 1 (src2 is read).
REQ-008 SHALL have ports: ex_valid in 1; ex_wb_en in 1; ex_mem_read in 1; ex_dest in RA_W.
REQ-009 SHALL have ports: mem_wb_en in 1; mem_dest in RA_W.
REQ-010 SHALL have ports: branch_taken in 1 (from EXE); ex_s in 1 (S bit of EXE instr); ex_status in ST_W.
REQ-011 SHALL have ports: freeze out 1 (hold PC and IF/ID); flush out 1 (bubble IF/ID and ID/EX).
REQ-012 SHALL have ports: fwd_sel1 out 2; fwd_sel2 out 2 (00 regfile, 01 EXE result, 10 MEM result).
REQ-013 SHALL have ports: status out ST_W; state out 2; stall_cnt out CNT_W; flush_cnt out CNT_W.

Function
REQ-014 SHALL compute hit_ex(s) = ex_wb_en & ex_dest==s and hit_mem(s) = mem_wb_en & mem_dest==s; src2 terms gated by id_use_src2.
REQ-015 SHALL, FWD_EN=0, assert hazard = id_valid & (hit_ex|hit_mem on src1 or src2), combinationally, same cycle.
REQ-016 SHALL, FWD_EN=1, assert hazard = id_valid & ex_mem_read & (hit_ex(src1) | hit_ex(src2)) only.
REQ-017 SHALL, FWD_EN=1, drive fwd_selN = 01 on hit_ex, else 10 on hit_mem, else 00; EXE has priority over MEM.
REQ-018 SHALL tie fwd_sel1/fwd_sel2 to 00 when FWD_EN=0.
REQ-019 SHALL drive flush = branch_taken | (state==FLUSH); freeze = hazard & ~flush.
REQ-020 SHALL implement states RUN=00, STALL=01, FLUSH=10, registered on posedge clk.
REQ-021 SHALL transition: any state & branch_taken & FLUSH_CYC>1 -> FLUSH, load fcnt=FLUSH_CYC-1.
REQ-022 SHALL transition: FLUSH with fcnt>1 -> FLUSH, fcnt-1; fcnt==1 and no branch_taken -> RUN.
REQ-023 SHALL transition: non-FLUSH & ~branch_taken & hazard -> STALL; STALL & ~hazard -> RUN.
REQ-024 SHALL, with FLUSH_CYC=1, never enter FLUSH; flush is exactly branch_taken.
REQ-025 SHALL restart fcnt at FLUSH_CYC-1 on branch_taken arriving while in FLUSH.
REQ-026 SHALL update status <= ex_status on the edge where ex_valid & ex_s, independent of branch_taken; otherwise hold.
REQ-027 SHALL increment stall_cnt each cycle freeze=1, saturating at all-ones.
REQ-028 SHALL increment flush_cnt once per cycle branch_taken=1, saturating at all-ones.
REQ-029 SHALL give branch_taken priority over hazard in the same cycle: flush=1, freeze=0, stall_cnt unchanged.

Reset
REQ-030 SHALL, on posedge clk with rst=0, set state=RUN, fcnt=0, status=0, stall_cnt=0, flush_cnt=0.
REQ-031 SHALL force freeze=0 and flush=0 combinationally while rst=0, including mid-stall or mid-flush.
REQ-032 SHALL resume normal decoding the first cycle rst=1 with no residual flush cycles.

Verification
REQ-033 FWD_EN=0: id_src1=3, ex_wb_en=1, ex_dest=3 for 2 cycles -> freeze=1 both cycles, state=STALL, stall_cnt=2.
REQ-034 FWD_EN=1: src1=5 hits ex_dest=5 (no load), src2=6 hits mem_dest=6 -> freeze=0, fwd_sel1=01, fwd_sel2=10; same with ex_mem_read=1 -> freeze=1.
REQ-035 FLUSH_CYC=3: branch_taken pulse 1 cycle -> flush=1 for 3 cycles, state FLUSH 2 cycles, flush_cnt=1; second pulse in cycle 2 -> flush extends to 3 cycles after it.
REQ-036 Hazard and branch_taken same cycle -> flush=1, freeze=0, stall_cnt unchanged.
REQ-037 ex_valid=1, ex_s=1, ex_status=4'b1010 -> status=1010 next edge; ex_s=0 next -> holds 1010.
REQ-038 rst=0 during FLUSH with stall_cnt=7 -> freeze=flush=0 immediately, all counters/status 0 after edge, RUN.
